fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Instruction buffer between the fetch stage and the decoder. Takes up to IW
//  types::fet_bundle_t entries per cycle from fetch and compacts them in lane order.
//  Presents up to OW oldest entries to the decoder, which consumes a counted prefix.
//  Decouples fetch-side stalls and bubbles from decode. Cleared on pipeline flush (redirect).
// PARAMETERS
//  DEPTH  16  entry count; power of two, >= IW+OW
//  IW     2   enqueue lanes per cycle
//  OW     2   dequeue lanes per cycle
// PORTS
//  clk        in   1            clock; all state updates on rising edge
//  rstn       in   1            synchronous active-low reset
//  flush      in   1            drop all entries (redirect/exception)
//  enq_data   in   IW x fet_bundle_t  fetch lanes; per-lane valid = enq_data[i].valid
//  enq_ready  out  1            queue can accept a full IW-lane group this cycle
//  deq_data   out  OW x fet_bundle_t  oldest entries; deq_data[j].valid=1 iff j<count
//  deq_num    in   $clog2(OW+1) entries taken by decoder this cycle
//  count      out  $clog2(DEPTH+1) occupied entries
// BEHAVIOUR
//  - Storage: DEPTH-entry circular array. Pointers head/tail are $clog2(DEPTH)+1 bits.
//    The MSB is the wrap bit. count=tail-head (mod 2*DEPTH); empty iff count==0.
//  - Reset (rstn=0 at edge): head=tail=0. Outputs next cycle: count=0, enq_ready=1,
//    all deq_data[j].valid=0. Storage contents are don't-care. Reset overrides flush, enq and deq.
//  - enq_ready = (DEPTH-count) >= IW. It uses the registered count only and ignores
//    same-cycle dequeue (conservative). It is combinational from state only.
//  - Enqueue fires when enq_ready=1 and flush=0. Let k = number of lanes with valid=1.
//    The k valid lanes are written in ascending lane order at tail..tail+k-1.
//    Invalid lanes are skipped, not written. tail+=k. Stored entries keep valid=1.
//    If enq_ready=0, fetch must hold its data; the queue writes nothing.
//  - Dequeue: deq_data[j] = entry[head+j] (mod DEPTH) for j<count, read combinationally.
//    For j>=count, deq_data[j] is all-zero. head+=deq_num on the edge.
//    Decoder guarantees deq_num <= min(count,OW). Violation is a bench assertion error.
//    The RTL then clamps deq_num to min(count,OW).
//  - Latency: an entry enqueued at edge N is visible on deq_data from edge N onward,
//    i.e. one cycle after presentation. No same-cycle bypass.
//  - Simultaneous enq+deq: both apply on the same edge. count_next = count + k - deq_num.
//  - Order: strict FIFO across lanes and cycles. deq_data[0] is always the oldest.
//  - Wrap-around: index = ptr[$clog2(DEPTH)-1:0]. A group straddling DEPTH-1 -> 0 is
//    split correctly, on both the enqueue and dequeue sides.
//  - Full: count==DEPTH means enq_ready=0 and all deq lanes are valid, subject to OW.
//  - flush=1: at the edge, head=tail=0 and count=0. Enqueue and dequeue that cycle are ignored.
//    deq_data shows the pre-flush contents in the flush cycle. The decoder kills them
//    on flush itself.
//  - No other state: no FSM beyond the pointers. No combinational path from enq_data
//    to enq_ready, or from deq_num to any output.
// TESTING
//  T1 reset: rstn=0 for 2 cycles with enq traffic -> count=0, enq_ready=1, deq_data[*].valid=0.
//  T2 compaction: one cycle, lane0.valid=0 pc=0x1000, lane1.valid=1 pc=0x1004 ->
//     count=1, deq_data[0].pc=0x1004, deq_data[1].valid=0.
//  T3 fill/full: 8 cycles of 2 valid lanes, deq_num=0 -> count=16, enq_ready=0.
//     9th group is held by fetch, count stays 16. deq_num=2 -> count=14, enq_ready=1.
//  T4 wrap: stream pc=0x0,0x4,... with deq_num=2 every cycle for 40 cycles ->
//     pcs appear on deq lanes strictly ascending by 4, none lost or duplicated across index 15->0.
//  T5 simultaneous: count=5, enq k=2, deq_num=1 -> count=6. New entries are at positions 5 and 6
//     of the order.
//  T6 flush: count=10 with enq valid and deq_num=2 at flush=1 -> next cycle count=0,
//     enq_ready=1. Next-cycle enq pc=0x8000 -> deq_data[0].pc=0x8000.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: compacts up to IW valid fetch lanes per cycle
// into a circular store and presents the OW oldest entries to the decoder.

package types;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } fet_bundle_t;
endpackage

module fetch_queue #(
    parameter int DEPTH = 16,
    parameter int IW    = 2,
    parameter int OW    = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  types::fet_bundle_t           enq_data [IW],
    output logic                         enq_ready,
    output types::fet_bundle_t           deq_data [OW],
    input  logic [$clog2(OW+1)-1:0]      deq_num,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = $clog2(IW + 1);
    localparam int DW = $clog2(OW + 1);

    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [PW-1:0]       occ;
    types::fet_bundle_t  mem [DEPTH];

    logic                enq_fire;
    logic [KW-1:0]       enq_k;
    logic [KW-1:0]       lane_off [IW];
    logic [IW-1:0]       lane_wr;
    logic [AW-1:0]       lane_idx [IW];
    logic [PW-1:0]       lane_ptr;
    logic [PW-1:0]       deq_lim;
    logic [DW-1:0]       deq_eff;

    // The extra wrap bit makes tail-head the true occupancy, so full and empty differ.
    assign occ       = tail_q - head_q;
    assign count     = CW'(occ);
    assign enq_ready = (PW'(DEPTH) - occ) >= PW'(IW);
    assign enq_fire  = enq_ready & ~flush;

    // Each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        enq_k    = '0;
        lane_ptr = '0;
        for (int i = 0; i < IW; i++) begin
            lane_off[i] = enq_k;
            lane_ptr    = tail_q + PW'(enq_k);
            lane_idx[i] = lane_ptr[AW-1:0];
            lane_wr[i]  = enq_fire & enq_data[i].valid;
            if (enq_data[i].valid) begin
                enq_k = enq_k + KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < IW; i++) begin
            if (lane_wr[i]) begin
                mem[lane_idx[i]] <= enq_data[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < OW; gi++) begin : g_deq
            logic [PW-1:0] rd_ptr;
            assign rd_ptr       = head_q + PW'(gi);
            assign deq_data[gi] = (PW'(gi) < occ) ? mem[rd_ptr[AW-1:0]] : '0;
        end
    endgenerate

    // An over-asking decoder is clamped to what is actually presented.
    always_comb begin
        deq_lim = (occ < PW'(OW)) ? occ : PW'(OW);
        deq_eff = (PW'(deq_num) > deq_lim) ? DW'(deq_lim) : deq_num;
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            head_d = head_q + PW'(deq_eff);
            if (enq_fire) begin
                tail_d = tail_q + PW'(enq_k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule
